// File: rtl/alu_rs_scheduler_pkg.sv
// Shared constants and types for the ALU reservation station: micro-op codes,
// ROB tag width, word types, and the station entry / issue register layouts.
package alu_rs_scheduler_pkg;

  localparam int OPENUM_W = 5;
  localparam int ROB_ID_W = 4;

  typedef logic [31:0] DATA_TYPE;
  typedef logic [31:0] ADDR_TYPE;

  localparam logic     TRUE      = 1'b1;
  localparam logic     FALSE     = 1'b0;
  localparam DATA_TYPE ZERO_WORD = 32'h0;
  localparam ADDR_TYPE ZERO_ADDR = 32'h0;

  localparam logic [OPENUM_W-1:0] OPENUM_NOP   = 5'd0;
  localparam logic [OPENUM_W-1:0] OPENUM_LUI   = 5'd1;
  localparam logic [OPENUM_W-1:0] OPENUM_AUIPC = 5'd2;
  localparam logic [OPENUM_W-1:0] OPENUM_JAL   = 5'd3;
  localparam logic [OPENUM_W-1:0] OPENUM_JALR  = 5'd4;
  localparam logic [OPENUM_W-1:0] OPENUM_BEQ   = 5'd5;
  localparam logic [OPENUM_W-1:0] OPENUM_BNE   = 5'd6;
  localparam logic [OPENUM_W-1:0] OPENUM_BLT   = 5'd7;
  localparam logic [OPENUM_W-1:0] OPENUM_BGE   = 5'd8;
  localparam logic [OPENUM_W-1:0] OPENUM_BLTU  = 5'd9;
  localparam logic [OPENUM_W-1:0] OPENUM_BGEU  = 5'd10;
  localparam logic [OPENUM_W-1:0] OPENUM_ADDI  = 5'd11;
  localparam logic [OPENUM_W-1:0] OPENUM_SLTI  = 5'd12;
  localparam logic [OPENUM_W-1:0] OPENUM_SLTIU = 5'd13;
  localparam logic [OPENUM_W-1:0] OPENUM_XORI  = 5'd14;
  localparam logic [OPENUM_W-1:0] OPENUM_ORI   = 5'd15;
  localparam logic [OPENUM_W-1:0] OPENUM_ANDI  = 5'd16;
  localparam logic [OPENUM_W-1:0] OPENUM_SLLI  = 5'd17;
  localparam logic [OPENUM_W-1:0] OPENUM_SRLI  = 5'd18;
  localparam logic [OPENUM_W-1:0] OPENUM_SRAI  = 5'd19;
  localparam logic [OPENUM_W-1:0] OPENUM_ADD   = 5'd20;
  localparam logic [OPENUM_W-1:0] OPENUM_SUB   = 5'd21;
  localparam logic [OPENUM_W-1:0] OPENUM_SLL   = 5'd22;
  localparam logic [OPENUM_W-1:0] OPENUM_SLT   = 5'd23;
  localparam logic [OPENUM_W-1:0] OPENUM_SLTU  = 5'd24;
  localparam logic [OPENUM_W-1:0] OPENUM_XOR   = 5'd25;
  localparam logic [OPENUM_W-1:0] OPENUM_SRL   = 5'd26;
  localparam logic [OPENUM_W-1:0] OPENUM_SRA   = 5'd27;
  localparam logic [OPENUM_W-1:0] OPENUM_OR    = 5'd28;
  localparam logic [OPENUM_W-1:0] OPENUM_AND   = 5'd29;

  typedef struct packed {
    logic                busy;
    logic [OPENUM_W-1:0] openum;
    DATA_TYPE            V1;
    DATA_TYPE            V2;
    logic                Q1_busy;
    logic                Q2_busy;
    logic [ROB_ID_W-1:0] Q1;
    logic [ROB_ID_W-1:0] Q2;
    DATA_TYPE            imm;
    ADDR_TYPE            pc;
    logic [ROB_ID_W-1:0] rob_id;
  } rs_entry_t;

  typedef struct packed {
    logic [OPENUM_W-1:0] openum;
    DATA_TYPE            V1;
    DATA_TYPE            V2;
    DATA_TYPE            imm;
    ADDR_TYPE            pc;
    logic [ROB_ID_W-1:0] rob_id;
  } issue_t;

  localparam issue_t ISSUE_NOP = '{OPENUM_NOP, ZERO_WORD, ZERO_WORD, ZERO_WORD, ZERO_ADDR, '0};

  typedef struct packed {
    logic     busy;
    DATA_TYPE val;
  } opnd_t;

  // The ALU bus wins when both buses carry the same tag.
  function automatic opnd_t snoop_operand(
    input logic                busy,
    input logic [ROB_ID_W-1:0] tag,
    input DATA_TYPE            val,
    input logic                a_vld,
    input logic [ROB_ID_W-1:0] a_tag,
    input DATA_TYPE            a_val,
    input logic                l_vld,
    input logic [ROB_ID_W-1:0] l_tag,
    input DATA_TYPE            l_val
  );
    opnd_t r;
    r.busy = busy;
    r.val  = val;
    if (busy && a_vld && (a_tag == tag)) begin
      r.busy = FALSE;
      r.val  = a_val;
    end else if (busy && l_vld && (l_tag == tag)) begin
      r.busy = FALSE;
      r.val  = l_val;
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_rs_scheduler_alu.sv
// Combinational integer ALU: arithmetic/logic results, branch resolution and
// jump target computation for one issued micro-op.
module alu_rs_scheduler_alu
  import alu_rs_scheduler_pkg::*;
(
  input  logic [OPENUM_W-1:0] openum_i,
  input  DATA_TYPE            V1_i,
  input  DATA_TYPE            V2_i,
  input  DATA_TYPE            imm_i,
  input  ADDR_TYPE            pc_i,
  output logic                valid_o,
  output DATA_TYPE            result_o,
  output ADDR_TYPE            pc_o,
  output logic                jump_o
);

  logic signed [31:0] s1, s2, si;
  logic               take;

  assign s1 = V1_i;
  assign s2 = V2_i;
  assign si = imm_i;

  always_comb begin
    valid_o  = TRUE;
    result_o = ZERO_WORD;
    pc_o     = ZERO_ADDR;
    jump_o   = FALSE;
    take     = FALSE;
    case (openum_i)
      OPENUM_LUI:   result_o = imm_i;
      OPENUM_AUIPC: result_o = pc_i + imm_i;
      OPENUM_JAL: begin
        result_o = pc_i + 32'd4;
        pc_o     = pc_i + imm_i;
        jump_o   = TRUE;
      end
      OPENUM_JALR: begin
        result_o = pc_i + 32'd4;
        pc_o     = (V1_i + imm_i) & ~32'd1;
        jump_o   = TRUE;
      end
      OPENUM_BEQ, OPENUM_BNE, OPENUM_BLT, OPENUM_BGE, OPENUM_BLTU, OPENUM_BGEU: begin
        case (openum_i)
          OPENUM_BEQ:  take = (V1_i == V2_i);
          OPENUM_BNE:  take = (V1_i != V2_i);
          OPENUM_BLT:  take = (s1 < s2);
          OPENUM_BGE:  take = (s1 >= s2);
          OPENUM_BLTU: take = (V1_i < V2_i);
          default:     take = (V1_i >= V2_i);
        endcase
        jump_o = take;
        pc_o   = take ? (pc_i + imm_i) : (pc_i + 32'd4);
      end
      OPENUM_ADDI:  result_o = V1_i + imm_i;
      OPENUM_SLTI:  result_o = 32'(s1 < si);
      OPENUM_SLTIU: result_o = 32'(V1_i < imm_i);
      OPENUM_XORI:  result_o = V1_i ^ imm_i;
      OPENUM_ORI:   result_o = V1_i | imm_i;
      OPENUM_ANDI:  result_o = V1_i & imm_i;
      OPENUM_SLLI:  result_o = V1_i << imm_i[4:0];
      OPENUM_SRLI:  result_o = V1_i >> imm_i[4:0];
      OPENUM_SRAI:  result_o = s1 >>> imm_i[4:0];
      OPENUM_ADD:   result_o = V1_i + V2_i;
      OPENUM_SUB:   result_o = V1_i - V2_i;
      OPENUM_SLL:   result_o = V1_i << V2_i[4:0];
      OPENUM_SLT:   result_o = 32'(s1 < s2);
      OPENUM_SLTU:  result_o = 32'(V1_i < V2_i);
      OPENUM_XOR:   result_o = V1_i ^ V2_i;
      OPENUM_SRL:   result_o = V1_i >> V2_i[4:0];
      OPENUM_SRA:   result_o = s1 >>> V2_i[4:0];
      OPENUM_OR:    result_o = V1_i | V2_i;
      OPENUM_AND:   result_o = V1_i & V2_i;
      default:      valid_o  = FALSE;
    endcase
  end

endmodule

// File: rtl/alu_rs_scheduler.sv
// ALU reservation station: buffers dispatched micro-ops, wakes operands from the
// ALU/LSB result buses, issues the lowest ready entry into the ALU each cycle.
module alu_rs_scheduler
  import alu_rs_scheduler_pkg::*;
#(
  parameter int RS_SIZE  = 16,
  parameter int RS_IDX_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rdy,
  input  logic                rollback,
  input  logic                disp_valid,
  input  logic [OPENUM_W-1:0] disp_openum,
  input  DATA_TYPE            disp_V1,
  input  DATA_TYPE            disp_V2,
  input  logic                disp_Q1_busy,
  input  logic                disp_Q2_busy,
  input  logic [ROB_ID_W-1:0] disp_Q1,
  input  logic [ROB_ID_W-1:0] disp_Q2,
  input  DATA_TYPE            disp_imm,
  input  ADDR_TYPE            disp_pc,
  input  logic [ROB_ID_W-1:0] disp_rob_id,
  output logic                rs_full,
  input  logic                lsb_cdb_valid,
  input  logic [ROB_ID_W-1:0] lsb_cdb_rob_id,
  input  DATA_TYPE            lsb_cdb_result,
  output logic                alu_cdb_valid,
  output logic [ROB_ID_W-1:0] alu_cdb_rob_id,
  output DATA_TYPE            alu_cdb_result,
  output ADDR_TYPE            alu_cdb_pc,
  output logic                alu_cdb_jump
);

  rs_entry_t             ent_q [RS_SIZE];
  rs_entry_t             ent_d [RS_SIZE];
  issue_t                iss_q, iss_d;
  rs_entry_t             disp_ent;
  opnd_t                 w1, w2;
  logic [RS_SIZE-1:0]    ready, busy_vec;
  logic                  sel_vld, free_vld;
  logic [RS_IDX_W-1:0]   sel_idx, free_idx;

  always_comb begin
    ready    = '0;
    busy_vec = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      busy_vec[i] = ent_q[i].busy;
      ready[i]    = ent_q[i].busy && !ent_q[i].Q1_busy && !ent_q[i].Q2_busy;
    end
  end

  assign rs_full = &busy_vec;

  // Descending scans so the lowest index wins.
  always_comb begin
    sel_vld  = FALSE;
    sel_idx  = '0;
    free_vld = FALSE;
    free_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (ready[i]) begin
        sel_vld = TRUE;
        sel_idx = RS_IDX_W'(i);
      end
      if (!busy_vec[i]) begin
        free_vld = TRUE;
        free_idx = RS_IDX_W'(i);
      end
    end
  end

  always_comb begin
    disp_ent        = '0;
    w1              = snoop_operand(disp_Q1_busy, disp_Q1, disp_V1,
                                    alu_cdb_valid, alu_cdb_rob_id, alu_cdb_result,
                                    lsb_cdb_valid, lsb_cdb_rob_id, lsb_cdb_result);
    w2              = snoop_operand(disp_Q2_busy, disp_Q2, disp_V2,
                                    alu_cdb_valid, alu_cdb_rob_id, alu_cdb_result,
                                    lsb_cdb_valid, lsb_cdb_rob_id, lsb_cdb_result);
    disp_ent.busy    = TRUE;
    disp_ent.openum  = disp_openum;
    disp_ent.V1      = w1.val;
    disp_ent.Q1_busy = w1.busy;
    disp_ent.Q1      = disp_Q1;
    disp_ent.V2      = w2.val;
    disp_ent.Q2_busy = w2.busy;
    disp_ent.Q2      = disp_Q2;
    disp_ent.imm     = disp_imm;
    disp_ent.pc      = disp_pc;
    disp_ent.rob_id  = disp_rob_id;
  end

  always_comb begin
    ent_d = ent_q;
    iss_d = ISSUE_NOP;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (ent_q[i].busy) begin
        ent_d[i].Q1_busy = snoop_operand(ent_q[i].Q1_busy, ent_q[i].Q1, ent_q[i].V1,
                                         alu_cdb_valid, alu_cdb_rob_id, alu_cdb_result,
                                         lsb_cdb_valid, lsb_cdb_rob_id, lsb_cdb_result).busy;
        ent_d[i].V1      = snoop_operand(ent_q[i].Q1_busy, ent_q[i].Q1, ent_q[i].V1,
                                         alu_cdb_valid, alu_cdb_rob_id, alu_cdb_result,
                                         lsb_cdb_valid, lsb_cdb_rob_id, lsb_cdb_result).val;
        ent_d[i].Q2_busy = snoop_operand(ent_q[i].Q2_busy, ent_q[i].Q2, ent_q[i].V2,
                                         alu_cdb_valid, alu_cdb_rob_id, alu_cdb_result,
                                         lsb_cdb_valid, lsb_cdb_rob_id, lsb_cdb_result).busy;
        ent_d[i].V2      = snoop_operand(ent_q[i].Q2_busy, ent_q[i].Q2, ent_q[i].V2,
                                         alu_cdb_valid, alu_cdb_rob_id, alu_cdb_result,
                                         lsb_cdb_valid, lsb_cdb_rob_id, lsb_cdb_result).val;
      end
    end
    if (sel_vld) begin
      iss_d.openum           = ent_q[sel_idx].openum;
      iss_d.V1               = ent_q[sel_idx].V1;
      iss_d.V2               = ent_q[sel_idx].V2;
      iss_d.imm              = ent_q[sel_idx].imm;
      iss_d.pc               = ent_q[sel_idx].pc;
      iss_d.rob_id           = ent_q[sel_idx].rob_id;
      ent_d[sel_idx].busy    = FALSE;
    end
    // Free slots come from registered state, so a just-selected slot is not reused this edge.
    if (disp_valid && free_vld) begin
      ent_d[free_idx] = disp_ent;
    end
    if (rollback) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        ent_d[i].busy = FALSE;
      end
      iss_d = ISSUE_NOP;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        ent_q[i] <= '0;
      end
      iss_q <= ISSUE_NOP;
    end else if (rdy) begin
      ent_q <= ent_d;
      iss_q <= iss_d;
    end
  end

  alu_rs_scheduler_alu u_alu (
    .openum_i (iss_q.openum),
    .V1_i     (iss_q.V1),
    .V2_i     (iss_q.V2),
    .imm_i    (iss_q.imm),
    .pc_i     (iss_q.pc),
    .valid_o  (alu_cdb_valid),
    .result_o (alu_cdb_result),
    .pc_o     (alu_cdb_pc),
    .jump_o   (alu_cdb_jump)
  );

  assign alu_cdb_rob_id = iss_q.rob_id;

endmodule

// File: tb/tb_alu_rs_scheduler.sv
// Directed bench for alu_rs_scheduler: ALU op table plus wakeup, fill, rdy-stall,
// rollback and reset sequences with hand-computed expectations.
module tb_alu_rs_scheduler;
  import alu_rs_scheduler_pkg::*;

  logic                clk = 1'b0;
  logic                rst_n, rdy, rollback, disp_valid;
  logic [OPENUM_W-1:0] disp_openum;
  logic [31:0]         disp_V1, disp_V2, disp_imm, disp_pc;
  logic                disp_Q1_busy, disp_Q2_busy;
  logic [ROB_ID_W-1:0] disp_Q1, disp_Q2, disp_rob_id;
  logic                rs_full;
  logic                lsb_cdb_valid;
  logic [ROB_ID_W-1:0] lsb_cdb_rob_id;
  logic [31:0]         lsb_cdb_result;
  logic                alu_cdb_valid;
  logic [ROB_ID_W-1:0] alu_cdb_rob_id;
  logic [31:0]         alu_cdb_result, alu_cdb_pc;
  logic                alu_cdb_jump;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_rs_scheduler dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .rollback(rollback),
    .disp_valid(disp_valid), .disp_openum(disp_openum),
    .disp_V1(disp_V1), .disp_V2(disp_V2),
    .disp_Q1_busy(disp_Q1_busy), .disp_Q2_busy(disp_Q2_busy),
    .disp_Q1(disp_Q1), .disp_Q2(disp_Q2),
    .disp_imm(disp_imm), .disp_pc(disp_pc), .disp_rob_id(disp_rob_id),
    .rs_full(rs_full),
    .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_rob_id(lsb_cdb_rob_id),
    .lsb_cdb_result(lsb_cdb_result),
    .alu_cdb_valid(alu_cdb_valid), .alu_cdb_rob_id(alu_cdb_rob_id),
    .alu_cdb_result(alu_cdb_result), .alu_cdb_pc(alu_cdb_pc),
    .alu_cdb_jump(alu_cdb_jump)
  );

  typedef struct {
    logic [OPENUM_W-1:0] op;
    logic [31:0]         v1, v2, imm, pc;
    logic [ROB_ID_W-1:0] rob;
    logic [31:0]         res, tpc;
    logic                jmp, chk_res, chk_pc;
  } vec_t;

  vec_t vt[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_disp(input logic [OPENUM_W-1:0] op, input logic [31:0] v1, input logic [31:0] v2,
                          input logic q1b, input logic [ROB_ID_W-1:0] q1,
                          input logic q2b, input logic [ROB_ID_W-1:0] q2,
                          input logic [31:0] imm, input logic [31:0] pc, input logic [ROB_ID_W-1:0] rob);
    disp_valid   = 1'b1;
    disp_openum  = op;
    disp_V1      = v1;
    disp_V2      = v2;
    disp_Q1_busy = q1b;
    disp_Q1      = q1;
    disp_Q2_busy = q2b;
    disp_Q2      = q2;
    disp_imm     = imm;
    disp_pc      = pc;
    disp_rob_id  = rob;
  endtask

  task automatic clr_disp();
    disp_valid   = 1'b0;
    disp_openum  = OPENUM_NOP;
    disp_V1      = '0;
    disp_V2      = '0;
    disp_Q1_busy = 1'b0;
    disp_Q1      = '0;
    disp_Q2_busy = 1'b0;
    disp_Q2      = '0;
    disp_imm     = '0;
    disp_pc      = '0;
    disp_rob_id  = '0;
  endtask

  initial begin
    vt[0]  = '{OPENUM_ADDI,  32'd5,        32'd0,  32'd7,        32'h1000, 4'd3,  32'd12,       32'h0,   1'b0, 1'b1, 1'b0};
    vt[1]  = '{OPENUM_ADD,   32'hFFFFFFFF, 32'd2,  32'd0,        32'h1000, 4'd1,  32'd1,        32'h0,   1'b0, 1'b1, 1'b0};
    vt[2]  = '{OPENUM_SUB,   32'd3,        32'd5,  32'd0,        32'h1000, 4'd2,  32'hFFFFFFFE, 32'h0,   1'b0, 1'b1, 1'b0};
    vt[3]  = '{OPENUM_SLT,   32'hFFFFFFFD, 32'd2,  32'd0,        32'h1000, 4'd4,  32'd1,        32'h0,   1'b0, 1'b1, 1'b0};
    vt[4]  = '{OPENUM_SLTU,  32'hFFFFFFFD, 32'd2,  32'd0,        32'h1000, 4'd5,  32'd0,        32'h0,   1'b0, 1'b1, 1'b0};
    vt[5]  = '{OPENUM_XOR,   32'h0000F0F0, 32'h0FF0, 32'd0,      32'h1000, 4'd6,  32'h0000FF00, 32'h0,   1'b0, 1'b1, 1'b0};
    vt[6]  = '{OPENUM_SRA,   32'h80000000, 32'd4,  32'd0,        32'h1000, 4'd7,  32'hF8000000, 32'h0,   1'b0, 1'b1, 1'b0};
    vt[7]  = '{OPENUM_SLLI,  32'd1,        32'd0,  32'd31,       32'h1000, 4'd8,  32'h80000000, 32'h0,   1'b0, 1'b1, 1'b0};
    vt[8]  = '{OPENUM_LUI,   32'd0,        32'd0,  32'h12345000, 32'h1000, 4'd9,  32'h12345000, 32'h0,   1'b0, 1'b1, 1'b0};
    vt[9]  = '{OPENUM_AUIPC, 32'd0,        32'd0,  32'h2000,     32'h100,  4'd10, 32'h2100,     32'h0,   1'b0, 1'b1, 1'b0};
    vt[10] = '{OPENUM_JAL,   32'd0,        32'd0,  32'h40,       32'h200,  4'd11, 32'h204,      32'h240, 1'b1, 1'b1, 1'b1};
    vt[11] = '{OPENUM_JALR,  32'h301,      32'd0,  32'd4,        32'h200,  4'd12, 32'h204,      32'h304, 1'b1, 1'b1, 1'b1};
    vt[12] = '{OPENUM_BLT,   32'hFFFFFFFF, 32'd1,  32'h20,       32'h100,  4'd13, 32'h0,        32'h120, 1'b1, 1'b0, 1'b1};
    vt[13] = '{OPENUM_BLTU,  32'hFFFFFFFF, 32'd1,  32'h20,       32'h100,  4'd14, 32'h0,        32'h0,   1'b0, 1'b0, 1'b0};
    vt[14] = '{OPENUM_BEQ,   32'd7,        32'd7,  32'hFFFFFFF0, 32'h400,  4'd15, 32'h0,        32'h3F0, 1'b1, 1'b0, 1'b1};
    vt[15] = '{OPENUM_BGE,   32'd1,        32'd2,  32'h20,       32'h100,  4'd0,  32'h0,        32'h0,   1'b0, 1'b0, 1'b0};

    rst_n          = 1'b0;
    rdy            = 1'b1;
    rollback       = 1'b0;
    lsb_cdb_valid  = 1'b0;
    lsb_cdb_rob_id = '0;
    lsb_cdb_result = '0;
    clr_disp();

    // Reset
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_full",   rs_full,        0);
    chk("rst_valid",  alu_cdb_valid,  0);
    chk("rst_rob",    alu_cdb_rob_id, 0);
    chk("rst_result", alu_cdb_result, 0);
    chk("rst_pc",     alu_cdb_pc,     0);
    chk("rst_jump",   alu_cdb_jump,   0);

    // Operation table: insert ready, nothing during select cycle, result after
    for (int k = 0; k < 16; k++) begin
      set_disp(vt[k].op, vt[k].v1, vt[k].v2, 1'b0, '0, 1'b0, '0, vt[k].imm, vt[k].pc, vt[k].rob);
      tick();
      clr_disp();
      chk($sformatf("v%0d_idle", k), alu_cdb_valid, 0);
      tick();
      chk($sformatf("v%0d_valid", k), alu_cdb_valid, 1);
      chk($sformatf("v%0d_rob", k), alu_cdb_rob_id, vt[k].rob);
      chk($sformatf("v%0d_jump", k), alu_cdb_jump, vt[k].jmp);
      if (vt[k].chk_res) chk($sformatf("v%0d_result", k), alu_cdb_result, vt[k].res);
      if (vt[k].chk_pc)  chk($sformatf("v%0d_pc", k), alu_cdb_pc, vt[k].tpc);
    end
    tick();

    // Wakeup from LSB one cycle after insert
    set_disp(OPENUM_ADD, 32'd1, 32'd0, 1'b0, '0, 1'b1, 4'd2, 32'd0, 32'h0, 4'd4);
    tick();
    clr_disp();
    tick();
    chk("dep_wait", alu_cdb_valid, 0);
    lsb_cdb_valid = 1'b1; lsb_cdb_rob_id = 4'd2; lsb_cdb_result = 32'd9;
    tick();
    lsb_cdb_valid = 1'b0;
    chk("dep_c1_valid", alu_cdb_valid, 0);
    tick();
    chk("dep_c2_valid",  alu_cdb_valid,  1);
    chk("dep_c2_rob",    alu_cdb_rob_id, 4);
    chk("dep_c2_result", alu_cdb_result, 10);
    tick();

    // Wakeup from LSB in the insert cycle
    set_disp(OPENUM_ADD, 32'd1, 32'd0, 1'b0, '0, 1'b1, 4'd2, 32'd0, 32'h0, 4'd4);
    lsb_cdb_valid = 1'b1; lsb_cdb_rob_id = 4'd2; lsb_cdb_result = 32'd9;
    tick();
    clr_disp();
    lsb_cdb_valid = 1'b0;
    chk("same_c1_valid", alu_cdb_valid, 0);
    tick();
    chk("same_c2_valid",  alu_cdb_valid,  1);
    chk("same_c2_rob",    alu_cdb_rob_id, 4);
    chk("same_c2_result", alu_cdb_result, 10);
    tick();

    // Fill all entries pending on tag 7, then release them together
    for (int i = 0; i < 16; i++) begin
      set_disp(OPENUM_ADDI, 32'd0, 32'd0, 1'b1, 4'd7, 1'b0, '0, 32'(i), 32'h0, 4'(i));
      tick();
    end
    clr_disp();
    chk("fill_full", rs_full, 1);
    lsb_cdb_valid = 1'b1; lsb_cdb_rob_id = 4'd7; lsb_cdb_result = 32'd100;
    tick();
    lsb_cdb_valid = 1'b0;
    chk("fill_full_woken", rs_full, 1);
    chk("fill_no_bcast",   alu_cdb_valid, 0);
    tick();
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("fill%0d_valid", i),  alu_cdb_valid,  1);
      chk($sformatf("fill%0d_rob", i),    alu_cdb_rob_id, 32'(i));
      chk($sformatf("fill%0d_result", i), alu_cdb_result, 32'd100 + 32'(i));
      if (i == 0) chk("fill_full_drop", rs_full, 0);
      tick();
    end
    chk("fill_drained", alu_cdb_valid, 0);

    // rdy low freezes a broadcast and ignores dispatch
    set_disp(OPENUM_ADDI, 32'd20, 32'd0, 1'b0, '0, 1'b0, '0, 32'd2, 32'h0, 4'd6);
    tick();
    clr_disp();
    tick();
    chk("rdy_pre_valid",  alu_cdb_valid,  1);
    chk("rdy_pre_result", alu_cdb_result, 22);
    rdy = 1'b0;
    set_disp(OPENUM_ADDI, 32'd1, 32'd0, 1'b0, '0, 1'b0, '0, 32'd1, 32'h0, 4'd11);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rdy%0d_valid", i),  alu_cdb_valid,  1);
      chk($sformatf("rdy%0d_rob", i),    alu_cdb_rob_id, 6);
      chk($sformatf("rdy%0d_result", i), alu_cdb_result, 22);
      chk($sformatf("rdy%0d_full", i),   rs_full,        0);
    end
    clr_disp();
    rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rdy_post%0d_valid", i), alu_cdb_valid, 0);
    end

    // Rollback with three pending entries and a live issue
    for (int i = 0; i < 3; i++) begin
      set_disp(OPENUM_ADD, 32'd0, 32'd1, 1'b1, 4'd5, 1'b0, '0, 32'd0, 32'h0, 4'(13 + i));
      tick();
    end
    set_disp(OPENUM_ADDI, 32'd3, 32'd0, 1'b0, '0, 1'b0, '0, 32'd4, 32'h0, 4'd12);
    tick();
    clr_disp();
    tick();
    chk("rb_pre_valid",  alu_cdb_valid,  1);
    chk("rb_pre_rob",    alu_cdb_rob_id, 12);
    chk("rb_pre_result", alu_cdb_result, 7);
    rollback = 1'b1;
    set_disp(OPENUM_ADDI, 32'd1, 32'd0, 1'b0, '0, 1'b0, '0, 32'd1, 32'h0, 4'd10);
    tick();
    rollback = 1'b0;
    clr_disp();
    chk("rb_valid", alu_cdb_valid, 0);
    chk("rb_full",  rs_full,       0);
    lsb_cdb_valid = 1'b1; lsb_cdb_rob_id = 4'd5; lsb_cdb_result = 32'd1;
    tick();
    lsb_cdb_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rb_after%0d_valid", i), alu_cdb_valid, 0);
      tick();
    end

    // Reset during a broadcast
    set_disp(OPENUM_ADDI, 32'd40, 32'd0, 1'b0, '0, 1'b0, '0, 32'd2, 32'h0, 4'd9);
    tick();
    clr_disp();
    tick();
    chk("rst2_pre_valid", alu_cdb_valid, 1);
    rst_n = 1'b0;
    tick();
    chk("rst2_valid",  alu_cdb_valid,  0);
    chk("rst2_rob",    alu_cdb_rob_id, 0);
    chk("rst2_result", alu_cdb_result, 0);
    rst_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_rs_scheduler.md
Name: alu_rs_scheduler

Overview:
- Reservation station and issue scheduler for the shared combinational ALU in the out-of-order core.
- Buffers dispatched ALU/branch/jump micro-ops and wakes up their operands by snooping the ALU and LSB result buses.
- Each cycle it picks one ready entry and drives it into an internal alu instance through an issue register.
- It broadcasts the ALU result, tagged with the ROB id, on the ALU CDB.

Parameters:
- RS_SIZE, 16, number of station entries (power of two).
- RS_IDX_W, 4, log2(RS_SIZE).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- rdy  in  1  global enable; when low, all state holds
- rollback  in  1  misprediction flush
- disp_valid  in  1  dispatcher inserts a micro-op this cycle
- disp_openum  in  OPENUM_W  operation code
- disp_V1 / disp_V2  in  32 each  operand values
- disp_Q1_busy / disp_Q2_busy  in  1 each  operand still pending
- disp_Q1 / disp_Q2  in  ROB_ID_W each  producing ROB tag
- disp_imm  in  32  immediate
- disp_pc  in  32  instruction PC
- disp_rob_id  in  ROB_ID_W  destination ROB tag
- rs_full  out  1  no free entry
- lsb_cdb_valid  in  1  LSB result bus valid
- lsb_cdb_rob_id  in  ROB_ID_W  LSB result tag
- lsb_cdb_result  in  32  LSB result value
- alu_cdb_valid  out  1  ALU result broadcast valid
- alu_cdb_rob_id  out  ROB_ID_W  ROB tag of the result
- alu_cdb_result  out  32  rd value
- alu_cdb_pc  out  32  branch/jump target
- alu_cdb_jump  out  1  taken flag

Behaviour:
- Reset (rst_n low at a clk edge):
  - All entries cleared to not busy.
  - Issue register cleared: openum = OPENUM_NOP, rob_id = 0, V1/V2/imm/pc = 0.
  - Outputs: alu_cdb_valid = 0, alu_cdb_result = 0, alu_cdb_pc = 0, alu_cdb_jump = 0, alu_cdb_rob_id = 0, rs_full = 0.
- rdy low: no entry, issue-register or output changes. Reset still takes effect.
- Entry contents: busy, openum, V1, V2, Q1_busy, Q2_busy, Q1, Q2, imm, pc, rob_id.
- rs_full: combinational from registered state, high when all RS_SIZE entries are busy. The dispatcher never asserts disp_valid while rs_full is high; an insert while full is dropped.
- Insert:
  - On disp_valid, the lowest-index free entry is written at the clk edge.
  - If a CDB (ALU or LSB) in the same cycle carries a tag matching a pending disp operand, that operand is stored resolved with the CDB value.
  - A newly inserted entry is not eligible for selection until the next cycle.
- Wakeup: at each edge, every busy entry with Qx_busy and Qx equal to a valid CDB tag captures the value and clears Qx_busy. The ALU CDB takes priority if both buses carry the same tag, which must not occur.
- Select:
  - Ready = busy and both Q busy bits clear, evaluated on registered state.
  - The lowest-index ready entry is copied into the issue register and freed at the same edge.
  - If no entry is ready, the issue register loads OPENUM_NOP.
  - An entry freed by selection can be reallocated in the next cycle, not the same one.
- Execute / broadcast:
  - The issue register drives the alu instance combinationally.
  - alu_cdb_* is the alu output paired with the issue register's rob_id; alu_cdb_valid = the alu valid output, low for OPENUM_NOP.
  - Latency from an entry becoming ready to broadcast is 2 edges: select edge, then the result is visible during the following cycle.
  - The ALU CDB feeds back into this block's own wakeup.
  - Back-to-back dependent ops: at best, one issue every 2 cycles.
- Rollback (sampled at a clk edge with rdy high):
  - All entries become not busy and the issue register loads OPENUM_NOP, so alu_cdb_valid is low the next cycle.
  - A disp_valid in the same cycle is ignored.
  - Rollback takes priority over insert, select and wakeup.
- Entry field widths are fixed; imm and pc pass through unchanged; no arithmetic is performed outside the alu.

Decomposition:
- Shared constant header holds:
  - OPENUM_W and the OPENUM_* codes, including OPENUM_NOP;
  - ROB_ID_W, DATA_TYPE, ADDR_TYPE;
  - TRUE/FALSE, ZERO_WORD, ZERO_ADDR.
- One sub-module: the existing alu, instantiated once and fed from the issue register.
- Free-entry and ready-entry priority encoders stay inline; no further sub-modules.

Test Plan:
- Reset: rst_n = 0 for 2 cycles, then 1 -> rs_full = 0, alu_cdb_valid = 0 and all CDB outputs 0 on the first cycle after release.
- Ready ADDI: insert OPENUM_ADDI with V1 = 5, imm = 7, rob_id = 3, both Q clear, at cycle 0 -> cycle 1 selected; during cycle 2 alu_cdb_valid = 1, rob_id = 3, result = 12.
- Dependency wakeup:
  - Insert ADD (rob 4, V1 = 1, Q2 = 2 busy), then lsb_cdb_valid with rob 2, value 9 -> broadcast rob 4, result 10, exactly 2 cycles after the LSB CDB cycle.
  - Repeat with the LSB CDB in the same cycle as the insert -> same result.
- Fill: insert 16 ops all pending on rob 7 -> rs_full = 1. Broadcast tag 7 -> the 16 ops issue in index order over 16 consecutive cycles and rs_full drops after the first select.
- Branch: BLT with V1 = -1 (0xFFFFFFFF), V2 = 1, pc = 0x100, imm = 0x20 -> alu_cdb_jump = 1, alu_cdb_pc = 0x120.
- Rollback: with 3 busy entries and one op in the issue register, assert rollback together with disp_valid -> next cycle alu_cdb_valid = 0, rs_full = 0, and no later broadcasts. Also hold rdy low for 3 cycles mid-sequence -> outputs and state frozen.
